// File: rtl/moore_pkg.sv
// Shared constants and helpers for the Moore ring selector family.
package moore_pkg;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;

  // Index width that never collapses to zero bits for tiny rings.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/moore_ring_next.sv
// Next-state and flag-event logic for the ring selector; purely combinational.
module moore_ring_next
  import moore_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WRAP   = MODE_WRAP,
  localparam int SEL_W = clog2_min1(NUM_CH)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             adv,
  input  logic             dir,
  input  logic             ld,
  input  logic [SEL_W-1:0] ld_sel,
  output logic [SEL_W-1:0] next_sel,
  output logic             set_wrap,
  output logic             set_at_end,
  output logic             clr_at_end,
  output logic             set_ld_err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

  logic ld_ok;
  logic sel_bad;

  // Compare in int width so power-of-two rings do not produce constant compares.
  assign ld_ok   = (int'(ld_sel) < NUM_CH);
  assign sel_bad = (int'(sel) >= NUM_CH);

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    next_sel   = sel;
    set_wrap   = 1'b0;
    set_at_end = 1'b0;
    clr_at_end = 1'b0;
    set_ld_err = 1'b0;

    if (ld && ld_ok) begin
      next_sel   = ld_sel;
      clr_at_end = 1'b1;
    end else if (sel_bad) begin
      next_sel   = '0;
      clr_at_end = 1'b1;
      set_ld_err = ld;
    end else if (ld) begin
      set_ld_err = 1'b1;
    end else if (adv) begin
      if (dir == DIR_UP) begin
        if (sel != LAST) begin
          next_sel   = sel + 1'b1;
          clr_at_end = 1'b1;
        end else if (WRAP == MODE_WRAP) begin
          next_sel   = '0;
          set_wrap   = 1'b1;
          clr_at_end = 1'b1;
        end else begin
          set_at_end = 1'b1;
        end
      end else begin
        if (sel != '0) begin
          next_sel   = sel - 1'b1;
          clr_at_end = 1'b1;
        end else if (WRAP == MODE_WRAP) begin
          next_sel   = LAST;
          set_wrap   = 1'b1;
          clr_at_end = 1'b1;
        end else begin
          set_at_end = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/moore_ring_sel.sv
// NUM_CH-state Moore ring selector: registered index steps/loads and picks a data channel onto y.
module moore_ring_sel
  import moore_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int NUM_CH = 4,
  parameter int WRAP   = MODE_WRAP,
  localparam int SEL_W = clog2_min1(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adv,
  input  logic                    dir,
  input  logic                    ld,
  input  logic [SEL_W-1:0]        ld_sel,
  input  logic [NUM_CH*WIDTH-1:0] d_in,
  output logic [WIDTH-1:0]        y,
  output logic [SEL_W-1:0]        sel,
  output logic                    wrap,
  output logic                    at_end,
  output logic                    ld_err
);

  logic [SEL_W-1:0] next_sel;
  logic             set_wrap;
  logic             set_at_end;
  logic             clr_at_end;
  logic             set_ld_err;

  moore_ring_next #(
    .NUM_CH (NUM_CH),
    .WRAP   (WRAP)
  ) u_next (
    .sel        (sel),
    .adv        (adv),
    .dir        (dir),
    .ld         (ld),
    .ld_sel     (ld_sel),
    .next_sel   (next_sel),
    .set_wrap   (set_wrap),
    .set_at_end (set_at_end),
    .clr_at_end (clr_at_end),
    .set_ld_err (set_ld_err)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= '0;
      wrap   <= 1'b0;
      at_end <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      sel    <= next_sel;
      wrap   <= set_wrap;
      ld_err <= set_ld_err;
      if (set_at_end)      at_end <= 1'b1;
      else if (clr_at_end) at_end <= 1'b0;
    end
  end

  // Output mux depends only on the registered index and channel data.
  always_comb begin
    y = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) y = d_in[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_moore_ring_sel.sv
// Bench for moore_ring_sel: three configurations (4/wrap, 4/saturate, 5/wrap) share one stimulus.
module tb_moore_ring_sel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adv = 1'b0;
  logic        dir = 1'b0;
  logic        ld  = 1'b0;
  logic [2:0]  ld_sel = '0;
  logic [11:0] d4 = {3'd7, 3'd5, 3'd2, 3'd1};
  logic [14:0] d5 = {3'd6, 3'd4, 3'd3, 3'd7, 3'd1};

  logic [2:0] y_a, y_b, y_c;
  logic [1:0] sel_a, sel_b;
  logic [2:0] sel_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       at_end_a, at_end_b, at_end_c;
  logic       ld_err_a, ld_err_b, ld_err_c;

  int total = 0;
  int bad   = 0;

  moore_ring_sel #(.WIDTH(3), .NUM_CH(4), .WRAP(1)) u_a (
    .clk(clk), .rst(rst), .adv(adv), .dir(dir), .ld(ld), .ld_sel(ld_sel[1:0]),
    .d_in(d4), .y(y_a), .sel(sel_a), .wrap(wrap_a), .at_end(at_end_a), .ld_err(ld_err_a));

  moore_ring_sel #(.WIDTH(3), .NUM_CH(4), .WRAP(0)) u_b (
    .clk(clk), .rst(rst), .adv(adv), .dir(dir), .ld(ld), .ld_sel(ld_sel[1:0]),
    .d_in(d4), .y(y_b), .sel(sel_b), .wrap(wrap_b), .at_end(at_end_b), .ld_err(ld_err_b));

  moore_ring_sel #(.WIDTH(3), .NUM_CH(5), .WRAP(1)) u_c (
    .clk(clk), .rst(rst), .adv(adv), .dir(dir), .ld(ld), .ld_sel(ld_sel),
    .d_in(d5), .y(y_c), .sel(sel_c), .wrap(wrap_c), .at_end(at_end_c), .ld_err(ld_err_c));

  always #5 clk = ~clk;

  // Reference model: index as a plain integer on a ring of n positions.
  int n_ch  [3] = '{4, 4, 5};
  bit wraps [3] = '{1'b1, 1'b0, 1'b1};
  int m_sel [3];
  bit m_wrap[3];
  bit m_end [3];
  bit m_err [3];

  function automatic int chan(int i, int k);
    logic [14:0] v;
    v = (i < 2) ? {3'b0, d4} : d5;
    return int'((v >> (3 * k)) & 15'd7);
  endfunction

  function automatic int obs_sel(int i);
    return (i == 0) ? int'(sel_a) : (i == 1) ? int'(sel_b) : int'(sel_c);
  endfunction
  function automatic int obs_y(int i);
    return (i == 0) ? int'(y_a) : (i == 1) ? int'(y_b) : int'(y_c);
  endfunction
  function automatic bit obs_wrap(int i);
    return (i == 0) ? wrap_a : (i == 1) ? wrap_b : wrap_c;
  endfunction
  function automatic bit obs_end(int i);
    return (i == 0) ? at_end_a : (i == 1) ? at_end_b : at_end_c;
  endfunction
  function automatic bit obs_err(int i);
    return (i == 0) ? ld_err_a : (i == 1) ? ld_err_b : ld_err_c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sel[i] = 0; m_wrap[i] = 0; m_end[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int tgt;
      int t;
      tgt = (i < 2) ? int'(ld_sel) % 4 : int'(ld_sel);
      m_wrap[i] = 0;
      m_err[i]  = 0;
      if (ld) begin
        if (tgt < n_ch[i]) begin m_sel[i] = tgt; m_end[i] = 0; end
        else m_err[i] = 1;
      end else if (adv) begin
        t = m_sel[i] + (dir ? -1 : 1);
        if (t >= 0 && t < n_ch[i]) begin m_sel[i] = t; m_end[i] = 0; end
        else if (wraps[i]) begin m_sel[i] = (t + n_ch[i]) % n_ch[i]; m_wrap[i] = 1; end
        else m_end[i] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    #3 rst = 1'b0;
    adv = 1'b1; dir = 1'b0;
    tick(); tick();
    adv = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++;
    if (sel_a !== 2'd0 || y_a !== 3'd1) begin
      bad++; $display("FAIL reset_async sel=%0d y=%0d want sel=0 y=1", sel_a, y_a);
    end
    total++;
    if ({wrap_a, at_end_a, ld_err_a, wrap_b, at_end_b, ld_err_b, wrap_c, at_end_c, ld_err_c} !== 9'b0) begin
      bad++; $display("FAIL reset_flags got nonzero flag want all 0");
    end
    total++;
    if (sel_b !== 2'd0 || sel_c !== 3'd0 || y_c !== 3'd1) begin
      bad++; $display("FAIL reset_others sel_b=%0d sel_c=%0d y_c=%0d want 0 0 1", sel_b, sel_c, y_c);
    end
    tick();
    #3 rst = 1'b0;
    tick();
    total++;
    if (sel_a !== 2'd0) begin
      bad++; $display("FAIL reset_release sel=%0d want 0", sel_a);
    end
  endtask

  task automatic test_wrap_up();
    int exp_sel [5] = '{1, 2, 3, 0, 1};
    int exp_y   [5] = '{2, 5, 7, 1, 2};
    adv = 1'b1; dir = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (int'(sel_a) !== exp_sel[c] || int'(y_a) !== exp_y[c] || wrap_a !== (c == 3)) begin
        bad++;
        $display("FAIL wrap_up[%0d] sel=%0d y=%0d wrap=%0b want sel=%0d y=%0d wrap=%0b",
                 c, sel_a, y_a, wrap_a, exp_sel[c], exp_y[c], c == 3);
      end
    end
    adv = 1'b0;
  endtask

  task automatic test_wrap_down();
    ld = 1'b1; ld_sel = 3'd0;
    tick();
    ld = 1'b0; adv = 1'b1; dir = 1'b1;
    tick();
    total++;
    if (sel_a !== 2'd3 || y_a !== 3'd7 || wrap_a !== 1'b1) begin
      bad++; $display("FAIL wrap_down sel=%0d y=%0d wrap=%0b want 3 7 1", sel_a, y_a, wrap_a);
    end
    total++;
    if (sel_b !== 2'd0 || at_end_b !== 1'b1 || wrap_b !== 1'b0) begin
      bad++; $display("FAIL sat_down_blocked sel=%0d at_end=%0b wrap=%0b want 0 1 0", sel_b, at_end_b, wrap_b);
    end
    adv = 1'b0;
    tick();
    total++;
    if (wrap_a !== 1'b0 || sel_a !== 2'd3) begin
      bad++; $display("FAIL wrap_pulse_len wrap=%0b sel=%0d want 0 3", wrap_a, sel_a);
    end
  endtask

  task automatic test_saturate();
    ld = 1'b1; ld_sel = 3'd3;
    tick();
    total++;
    if (at_end_b !== 1'b0) begin
      bad++; $display("FAIL sat_load_clears at_end=%0b want 0", at_end_b);
    end
    ld = 1'b0; adv = 1'b1; dir = 1'b0;
    tick(); tick();
    total++;
    if (sel_b !== 2'd3 || at_end_b !== 1'b1 || wrap_b !== 1'b0) begin
      bad++; $display("FAIL sat_up_blocked sel=%0d at_end=%0b wrap=%0b want 3 1 0", sel_b, at_end_b, wrap_b);
    end
    total++;
    if (at_end_a !== 1'b0) begin
      bad++; $display("FAIL wrap_at_end_tied at_end=%0b want 0", at_end_a);
    end
    adv = 1'b0;
    tick();
    total++;
    if (at_end_b !== 1'b1) begin
      bad++; $display("FAIL sat_idle_hold at_end=%0b want 1", at_end_b);
    end
    adv = 1'b1; dir = 1'b1;
    tick();
    total++;
    if (sel_b !== 2'd2 || at_end_b !== 1'b0) begin
      bad++; $display("FAIL sat_move_clears sel=%0d at_end=%0b want 2 0", sel_b, at_end_b);
    end
    adv = 1'b0;
  endtask

  task automatic test_load_err();
    ld = 1'b1; ld_sel = 3'd2;
    tick();
    ld_sel = 3'd6; adv = 1'b1; dir = 1'b0;
    tick();
    total++;
    if (sel_c !== 3'd2 || ld_err_c !== 1'b1) begin
      bad++; $display("FAIL ld_err_set sel=%0d ld_err=%0b want 2 1", sel_c, ld_err_c);
    end
    adv = 1'b0; ld_sel = 3'd4;
    tick();
    total++;
    if (sel_c !== 3'd4 || ld_err_c !== 1'b0 || y_c !== 3'd6) begin
      bad++; $display("FAIL ld_edge sel=%0d ld_err=%0b y=%0d want 4 0 6", sel_c, ld_err_c, y_c);
    end
    ld = 1'b0;
  endtask

  task automatic test_ld_over_adv();
    ld = 1'b1; ld_sel = 3'd3;
    tick();
    ld_sel = 3'd1; adv = 1'b1; dir = 1'b0;
    tick();
    total++;
    if (sel_a !== 2'd1 || wrap_a !== 1'b0) begin
      bad++; $display("FAIL ld_priority sel=%0d wrap=%0b want 1 0", sel_a, wrap_a);
    end
    ld = 1'b0; adv = 1'b0;
    for (int v = 3; v < 6; v++) begin
      d4[5:3] = 3'(v);
      #1;
      total++;
      if (int'(y_a) !== v) begin
        bad++; $display("FAIL comb_data y=%0d want %0d", y_a, v);
      end
    end
  endtask

  task automatic test_random();
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      ld     = ($urandom_range(0, 5) == 0);
      adv    = ($urandom_range(0, 3) != 0);
      dir    = 1'($urandom);
      ld_sel = 3'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        d4 = 12'($urandom);
        d5 = 15'($urandom);
      end
      model_step();
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_sel(i) !== m_sel[i] || obs_y(i) !== chan(i, m_sel[i]) || obs_wrap(i) !== m_wrap[i] ||
            obs_end(i) !== m_end[i] || obs_err(i) !== m_err[i]) begin
          bad++;
          $display("FAIL random[%0d] dut%0d sel=%0d y=%0d w=%0b e=%0b err=%0b want sel=%0d y=%0d w=%0b e=%0b err=%0b",
                   c, i, obs_sel(i), obs_y(i), obs_wrap(i), obs_end(i), obs_err(i),
                   m_sel[i], chan(i, m_sel[i]), m_wrap[i], m_end[i], m_err[i]);
        end
      end
    end
    ld = 1'b0; adv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_err();
    test_ld_over_adv();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
